// File: rtl/iterative_shifter.sv
// ---------------------------------------------------------------------------
// iterative_shifter
//   Multi-cycle shift unit for the execute stage. A request is accepted in
//   IDLE, then the working register is shifted by at most STEP bit positions
//   per clock until the full shift amount has been applied. The result is
//   held in DONE until the consumer takes it.
//
//   Optional feature: define ROTATE_EN to build the rotate datapath
//   (op[2]=1 selects rotate; op[1]=1 -> ROL, op[1]=0 -> ROR). When
//   ROTATE_EN is undefined, op[2] is ignored.
//
// Parameters
//   WIDTH      operand/result width (power of two, >= 8)
//   STEP       max bit positions shifted per clock (power of two, 1..WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   unit can accept a request (high only in IDLE)
//   a          operand (signed for SRA)
//   shamt      shift amount, 0..WIDTH-1
//   op         op[0] arithmetic, op[1] left, op[2] rotate
//   out_valid  result valid, held until consumed
//   out_ready  consumer accepts result
//   result     shifted value, meaningful while out_valid=1
// ---------------------------------------------------------------------------
module iterative_shifter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         a,
   input  logic [$clog2(WIDTH)-1:0] shamt,
   input  logic [2:0]               op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         result
);

   localparam int SHW = $clog2(WIDTH);
   // One extra bit so that STEP == WIDTH is representable.
   localparam logic [SHW:0] STEP_K  = (SHW+1)'(STEP);
   localparam logic [SHW:0] WIDTH_K = (SHW+1)'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e           state_q,     state_d;
   logic [WIDTH-1:0] w_q,         w_d;
   logic [SHW-1:0]   rem_q,       rem_d;
   logic             left_q,      left_d;
   logic             arith_q,     arith_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
`ifdef ROTATE_EN
   logic             rot_q,       rot_d;
`else
   // op[2] has no function without the rotate datapath.
   logic             unused_op2;
   assign unused_op2 = op[2];
`endif

   logic [SHW:0]     k;
   logic [WIDTH-1:0] step_val;

   // Amount applied this cycle: min(STEP, remaining).
   always_comb begin
      k = ({1'b0, rem_q} >= STEP_K) ? STEP_K : {1'b0, rem_q};
   end

   // One step of the selected operation on the working register. For SRA the
   // MSB of w is always the latched a[WIDTH-1], so >>> supplies the right fill.
   always_comb begin
      step_val = w_q >> k;
`ifdef ROTATE_EN
      if (rot_q) begin
         if (left_q) step_val = (w_q << k) | (w_q >> (WIDTH_K - k));
         else        step_val = (w_q >> k) | (w_q << (WIDTH_K - k));
      end else
`endif
      if (left_q)       step_val = w_q << k;
      else if (arith_q) step_val = $signed(w_q) >>> k;
   end

   // Next-state logic.
   // NOTE: every signal gets a default at the top of the block, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      rem_d       = rem_q;
      left_d      = left_q;
      arith_d     = arith_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef ROTATE_EN
      rot_d       = rot_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               w_d        = a;
               rem_d      = shamt;
               left_d     = op[1];
               arith_d    = op[0];
`ifdef ROTATE_EN
               rot_d      = op[2];
`endif
               in_ready_d = 1'b0;
               state_d    = (shamt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_d   = step_val;
            rem_d = rem_q - k[SHW-1:0];
            if (rem_q == k[SHW-1:0]) state_d = S_DONE;
         end
         S_DONE: begin
            // out_valid is registered, so it rises one edge after DONE is
            // entered and then holds until the handshake completes.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so that
   // every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         w_q         <= '0;
         rem_q       <= '0;
         left_q      <= 1'b0;
         arith_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef ROTATE_EN
         rot_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         rem_q       <= rem_d;
         left_q      <= left_d;
         arith_q     <= arith_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef ROTATE_EN
         rot_q       <= rot_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = w_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// ---------------------------------------------------------------------------
// tb_iterative_shifter
//   Directed bench for iterative_shifter (WIDTH=32, STEP=4). A reference
//   model computes each expected result directly from the operation's
//   definition; a compare process checks result against it on every cycle
//   out_valid is high. Directed vectors also check latency, literal results,
//   backpressure and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_iterative_shifter;

   localparam int WIDTH = 32;
   localparam int STEP  = 4;
   localparam int SHW   = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [SHW-1:0]   shamt;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;

   iterative_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .shamt     (shamt),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   int unsigned      cyc = 0;
   int unsigned      acc_cyc = 0;
   int               n_cmp = 0;
   int               n_bad = 0;
   logic [WIDTH-1:0] exp_result = '0;
   bit               exp_pending = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: whole shift applied at once from the operation's rules.
   function automatic logic [31:0] model(input logic [31:0] va, input int s, input logic [2:0] vop);
      logic [31:0] r;
      r = va;
`ifdef ROTATE_EN
      if (vop[2]) begin
         for (int i = 0; i < s; i++)
            r = vop[1] ? {r[30:0], r[31]} : {r[0], r[31:1]};
         return r;
      end
`endif
      if (vop[1])      r = va << s;
      else if (vop[0]) r = 32'($signed(va) >>> s);
      else             r = va >> s;
      return r;
   endfunction

   // Compare process: result must match the model whenever out_valid is high.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_pending) begin
            check("cmp_result", result, exp_result);
            check("cmp_in_ready_low", 32'(in_ready), 32'd0);
         end else begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
         end
      end
   end

   task automatic issue(input logic [31:0] ia, input int is, input logic [2:0] iop, input bit rdy);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      out_ready = rdy;
      a         = ia;
      shamt     = is[SHW-1:0];
      op        = iop;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc     = cyc;
      exp_result  = model(ia, is, iop);
      exp_pending = 1'b1;
      // Scramble inputs after accept: the unit must have latched them.
      in_valid = 1'b0;
      a        = ~ia;
      shamt    = ~is[SHW-1:0];
      op       = ~iop;
   endtask

   task automatic complete(input string name, input int is, input logic [31:0] lit, input int hold);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_latency"}, 32'(cyc - acc_cyc), 32'(1 + (is + STEP - 1) / STEP));
      check({name, "_literal"}, result, lit);
      if (hold > 0) begin
         // A competing request is presented while the result is held.
         in_valid = 1'b1;
         a        = 32'hDEAD_BEEF;
         shamt    = 5'd3;
         op       = 3'b000;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({name, "_hold_result"}, result, lit);
         end
         out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
      end else begin
         @(negedge clk);
      end
      check({name, "_consumed"}, 32'(out_valid), 32'd0);
      check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
      exp_pending = 1'b0;
   endtask

   task automatic run(input string name, input logic [31:0] ia, input int is,
                      input logic [2:0] iop, input logic [31:0] lit);
      check({name, "_model_pin"}, model(ia, is, iop), lit);
      issue(ia, is, iop, 1'b1);
      complete(name, is, lit, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      shamt     = '0;
      op        = '0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic shifts, including step-boundary amounts.
      run("srl31",   32'h8000_0000, 31, 3'b000, 32'h0000_0001);
      run("sra4",    32'h8000_0000, 4,  3'b001, 32'hF800_0000);
      run("sra31",   32'h7FFF_FFFF, 31, 3'b001, 32'h0000_0000);
      run("sll0",    32'h0000_0001, 0,  3'b010, 32'h0000_0001);
      run("sll5",    32'h0000_0001, 5,  3'b010, 32'h0000_0020);
      run("asl8",    32'h0000_00F0, 8,  3'b011, 32'h0000_F000);
      run("sra_neg", 32'hF000_00F0, 9,  3'b001, 32'hFFF8_0000);
      run("srl_pos", 32'h1234_5678, 12, 3'b000, 32'h0001_2345);

      // Backpressure: result held 5 cycles with a competing request pending.
      check("bp_model_pin", model(32'h0000_00FF, 6, 3'b000), 32'h0000_0003);
      issue(32'h0000_00FF, 6, 3'b000, 1'b0);
      complete("bp", 6, 32'h0000_0003, 5);

      // Asynchronous reset in the middle of a long shift.
      issue(32'hFFFF_0000, 20, 3'b000, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_pending = 1'b0;
      check("midreset_out_valid", 32'(out_valid), 32'd0);
      check("midreset_result", result, 32'd0);
      check("midreset_in_ready", 32'(in_ready), 32'd1);
      #1 rst_n = 1'b1;
      run("after_reset", 32'hFFFF_0000, 20, 3'b000, 32'h0000_0FFF);

`ifdef ROTATE_EN
      run("ror1",  32'h0000_0001, 1,  3'b100, 32'h8000_0000);
      run("rol4",  32'h8000_0000, 4,  3'b110, 32'h0000_0008);
      run("ror13", 32'h1234_5678, 13, 3'b101, 32'hB3C0_91A2);
`else
      run("op4_as_srl", 32'h0000_0010, 4, 3'b100, 32'h0000_0001);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
